// File: rtl/gpr_wr_arbiter_pkg.sv
// gpr_wr_arbiter_pkg
//   Shared widths and the starvation FSM encoding for the GPR write-port
//   arbiter and its MDU result FIFO.
package gpr_wr_arbiter_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_WIDTH      = 32;

  typedef enum logic [1:0] {
    WBA_IDLE  = 2'd0,
    WBA_WAIT  = 2'd1,
    WBA_STEAL = 2'd2
  } wba_state_e;

  // x0 is hard-wired to zero, so writes to it carry no architectural effect.
  function automatic logic is_x0(input logic [REG_ADDR_WIDTH-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/gpr_wr_arbiter_fifo.sv
// gpr_wr_arbiter_fifo
//   Synchronous FIFO of buffered MDU results {valid, addr, data} with a
//   per-entry address compare used by decode hazard detection.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   push, push_addr/data     write a new entry at the tail (caller ensures not full)
//   pop                      retire the head entry (caller ensures not empty)
//   head_addr, head_data     current head entry
//   count                    number of buffered entries (0..DEPTH)
//   query_addr, query_hit    1 when any valid entry targets query_addr
module gpr_wr_arbiter_fifo
  import gpr_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [REG_ADDR_WIDTH-1:0]   push_addr,
  input  logic [REG_WIDTH-1:0]        push_data,
  input  logic                        pop,
  output logic [REG_ADDR_WIDTH-1:0]   head_addr,
  output logic [REG_WIDTH-1:0]        head_data,
  output logic [$clog2(DEPTH):0]      count,
  input  logic [REG_ADDR_WIDTH-1:0]   query_addr,
  output logic                        query_hit
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]          ent_valid;
  logic [REG_ADDR_WIDTH-1:0] ent_addr [DEPTH];
  logic [REG_WIDTH-1:0]      ent_data [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      // Pop before push: the two pointers only coincide when empty or full,
      // and the caller never pops empty nor pushes full.
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_addr[wr_ptr]  <= push_addr;
        ent_data[wr_ptr]  <= push_data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_addr = ent_addr[rd_ptr];
  assign head_data = ent_data[rd_ptr];

  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == query_addr)) query_hit = 1'b1;
    end
  end

endmodule

// File: rtl/gpr_wr_arbiter.sv
// gpr_wr_arbiter
//   Shares the single GPR write port between the in-order write-back stage
//   (always wins) and buffered MDU results that drain into idle slots. A
//   starvation FSM requests a pipeline bubble once the FIFO head has lost
//   STARVE_MAX consecutive cycles.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   pipe_we, pipe_addr, pipe_data      write-back request
//   mdu_valid, mdu_ready, mdu_addr/data MDU result handshake
//   stall_pipe                         registered bubble request to the pipeline
//   pend_addr, pend_hit                decode query for a buffered result
//   gpr_we_id, addr_rd_id, data_rd_id  GPR write port
//   dbg_state                          starvation FSM state (wba_state_e)
module gpr_wr_arbiter
  import gpr_wr_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pipe_we,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_addr,
  input  logic [REG_WIDTH-1:0]      pipe_data,
  input  logic                      mdu_valid,
  output logic                      mdu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mdu_addr,
  input  logic [REG_WIDTH-1:0]      mdu_data,
  output logic                      stall_pipe,
  input  logic [REG_ADDR_WIDTH-1:0] pend_addr,
  output logic                      pend_hit,
  output logic                      gpr_we_id,
  output logic [REG_ADDR_WIDTH-1:0] addr_rd_id,
  output logic [REG_WIDTH-1:0]      data_rd_id,
  output logic [1:0]                dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  logic                      pipe_wins;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      head_lost;
  logic                      drains_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [REG_ADDR_WIDTH-1:0] head_addr;
  logic [REG_WIDTH-1:0]      head_data;
  logic                      query_hit;
  wba_state_e                state;
  logic [SC_W-1:0]           starve_cnt;

  // MDU handshake: a result transfers in any cycle where mdu_valid && mdu_ready
  // are both high; the MDU holds valid/addr/data stable until then. Ready is a
  // function of the registered count only, so a same-cycle pop never makes
  // room for a push into a full FIFO.
  assign mdu_ready = (fifo_count < CNT_W'(FIFO_DEPTH));

  // x0 results complete the handshake but are never buffered.
  assign fifo_push  = mdu_valid && mdu_ready && !is_x0(mdu_addr);

  // A pipe write to x0 is discarded and leaves the port free for the FIFO.
  assign pipe_wins  = pipe_we && !is_x0(pipe_addr);
  assign fifo_empty = (fifo_count == '0);
  assign fifo_pop   = !pipe_wins && !fifo_empty;
  assign head_lost  = pipe_wins && !fifo_empty;

  // The pop retires the last entry and no new one arrives behind it.
  assign drains_empty = (fifo_count == CNT_W'(1)) && !fifo_push;

  gpr_wr_arbiter_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_addr  (mdu_addr),
    .push_data  (mdu_data),
    .pop        (fifo_pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (fifo_count),
    .query_addr (pend_addr),
    .query_hit  (query_hit)
  );

  assign pend_hit = query_hit && !is_x0(pend_addr);

  // Grant mux: pipe pass-through, else FIFO head, else an idle port.
  always_comb begin
    gpr_we_id  = 1'b0;
    addr_rd_id = '0;
    data_rd_id = '0;
    if (pipe_wins) begin
      gpr_we_id  = 1'b1;
      addr_rd_id = pipe_addr;
      data_rd_id = pipe_data;
    end else if (fifo_pop) begin
      gpr_we_id  = 1'b1;
      addr_rd_id = head_addr;
      data_rd_id = head_data;
    end
  end

  // Starvation FSM. stall_pipe is registered alongside the state so it is
  // high exactly while the FSM sits in STEAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WBA_IDLE;
      starve_cnt <= '0;
      stall_pipe <= 1'b0;
    end else begin
      case (state)
        WBA_IDLE: begin
          starve_cnt <= '0;
          stall_pipe <= 1'b0;
          if (fifo_push) state <= WBA_WAIT;
        end
        WBA_WAIT: begin
          if (fifo_pop) begin
            starve_cnt <= '0;
            stall_pipe <= 1'b0;
            state      <= drains_empty ? WBA_IDLE : WBA_WAIT;
          end else if (head_lost) begin
            if (starve_cnt == SC_W'(STARVE_MAX - 1)) begin
              starve_cnt <= '0;
              stall_pipe <= 1'b1;
              state      <= WBA_STEAL;
            end else begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        WBA_STEAL: begin
          // The pipe may still win while it reacts to stall_pipe.
          if (fifo_pop) begin
            starve_cnt <= '0;
            stall_pipe <= 1'b0;
            state      <= drains_empty ? WBA_IDLE : WBA_WAIT;
          end
        end
        default: begin
          starve_cnt <= '0;
          stall_pipe <= 1'b0;
          state      <= WBA_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
module tb_gpr_wr_arbiter;
  import gpr_wr_arbiter_pkg::*;

  localparam int AW = REG_ADDR_WIDTH;
  localparam int DW = REG_WIDTH;
  localparam int EW = AW + DW;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          pipe_we;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_addr;
  logic [DW-1:0] mdu_data;
  logic          stall_pipe;
  logic [AW-1:0] pend_addr;
  logic          pend_hit;
  logic          gpr_we_id;
  logic [AW-1:0] addr_rd_id;
  logic [DW-1:0] data_rd_id;
  logic [1:0]    dbg_state;

  gpr_wr_arbiter #(
    .FIFO_DEPTH (2),
    .STARVE_MAX (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_addr   (mdu_addr),
    .mdu_data   (mdu_data),
    .stall_pipe (stall_pipe),
    .pend_addr  (pend_addr),
    .pend_hit   (pend_hit),
    .gpr_we_id  (gpr_we_id),
    .addr_rd_id (addr_rd_id),
    .data_rd_id (data_rd_id),
    .dbg_state  (dbg_state)
  );

  // Scoreboard: expected GPR writes {addr, data} in order of appearance
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  int n_checks = 0;
  int n_pass   = 0;
  logic [AW-1:0] t_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every GPR write is popped against the expected stream
  always @(negedge clk) begin
    if (gpr_we_id === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL gpr_write: got x%0d=%0h expected no write at %0t",
                 addr_rd_id, data_rd_id, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("gpr_write", {addr_rd_id, data_rd_id}, mon_exp);
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    pipe_we   = pwe;
    pipe_addr = pa;
    pipe_data = pd;
    mdu_valid = mv;
    mdu_addr  = ma;
    mdu_data  = md;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    pend_addr = 5'd5;
    idle();

    // Reset values
    sample();
    check("rst_we",    gpr_we_id,  1'b0);
    check("rst_addr",  addr_rd_id, '0);
    check("rst_data",  data_rd_id, '0);
    check("rst_stall", stall_pipe, 1'b0);
    check("rst_hit",   pend_hit,   1'b0);
    check("rst_ready", mdu_ready,  1'b1);
    check("rst_state", dbg_state,  WBA_IDLE);
    next_cycle();
    rst_n = 1'b1;
    sample();
    next_cycle();

    // MDU alone: accepted in N, written in N+1
    drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h0000_1234);
    sample();
    check("t2_ready_n", mdu_ready, 1'b1);
    check("t2_hit_n",   pend_hit,  1'b0);
    check("t2_we_n",    gpr_we_id, 1'b0);
    next_cycle();
    idle();
    exp_wr(5'd5, 32'h0000_1234);
    sample();
    check("t2_we_n1",  gpr_we_id, 1'b1);
    check("t2_hit_n1", pend_hit,  1'b1);
    next_cycle();
    sample();
    check("t2_hit_n2", pend_hit,  1'b0);
    check("t2_we_n2",  gpr_we_id, 1'b0);
    next_cycle();

    // Starvation: x7 loses 8 cycles, stall_pipe high from N+9
    pend_addr = 5'd7;
    for (int i = 0; i < 10; i++) begin
      t_addr = AW'(1 + (i % 3));
      drive(1'b1, t_addr, 32'h100 + i, (i == 0), 5'd7, 32'h0000_DEAD);
      exp_wr(t_addr, 32'h100 + i);
      sample();
      check("t3_stall", stall_pipe, (i == 9));
      if (i >= 1) check("t3_hit", pend_hit, 1'b1);
      next_cycle();
    end
    idle();
    exp_wr(5'd7, 32'h0000_DEAD);
    sample();
    check("t3_stall_m", stall_pipe, 1'b1);
    check("t3_state_m", dbg_state,  WBA_STEAL);
    check("t3_we_m",    gpr_we_id,  1'b1);
    next_cycle();
    sample();
    check("t3_stall_m1", stall_pipe, 1'b0);
    check("t3_hit_m1",   pend_hit,   1'b0);
    check("t3_we_m1",    gpr_we_id,  1'b0);
    next_cycle();

    // Full FIFO: x8, x9 buffered, x10 held until the registered count drops
    pend_addr = 5'd10;
    drive(1'b1, 5'd1, 32'h200, 1'b1, 5'd8, 32'h88);
    exp_wr(5'd1, 32'h200);
    sample();
    check("t4_ready_a", mdu_ready, 1'b1);
    next_cycle();
    drive(1'b1, 5'd2, 32'h201, 1'b1, 5'd9, 32'h99);
    exp_wr(5'd2, 32'h201);
    sample();
    check("t4_ready_a1", mdu_ready, 1'b1);
    next_cycle();
    drive(1'b1, 5'd3, 32'h202, 1'b1, 5'd10, 32'hAA);
    exp_wr(5'd3, 32'h202);
    sample();
    check("t4_ready_full", mdu_ready, 1'b0);
    check("t4_hit_held",   pend_hit,  1'b0);
    next_cycle();
    drive(1'b0, '0, '0, 1'b1, 5'd10, 32'hAA);
    exp_wr(5'd8, 32'h88);
    sample();
    check("t4_ready_pop", mdu_ready, 1'b0);
    check("t4_we_pop",    gpr_we_id, 1'b1);
    next_cycle();
    drive(1'b1, 5'd1, 32'h203, 1'b1, 5'd10, 32'hAA);
    exp_wr(5'd1, 32'h203);
    sample();
    check("t4_ready_after", mdu_ready, 1'b1);
    next_cycle();
    idle();
    exp_wr(5'd9, 32'h99);
    sample();
    check("t4_hit_x10",   pend_hit,  1'b1);
    check("t4_ready_two", mdu_ready, 1'b0);
    next_cycle();
    exp_wr(5'd10, 32'hAA);
    sample();
    check("t4_hit_last",  pend_hit,  1'b1);
    check("t4_ready_one", mdu_ready, 1'b1);
    next_cycle();
    sample();
    check("t4_we_done",    gpr_we_id,  1'b0);
    check("t4_hit_done",   pend_hit,   1'b0);
    check("t4_stall_done", stall_pipe, 1'b0);
    next_cycle();

    // x0 filtering
    drive(1'b1, 5'd2, 32'h300, 1'b1, 5'd4, 32'h55);
    exp_wr(5'd2, 32'h300);
    next_cycle();
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
    exp_wr(5'd4, 32'h55);
    sample();
    check("t5_we_x0pipe",   gpr_we_id,  1'b1);
    check("t5_addr_x0pipe", addr_rd_id, 5'd4);
    check("t5_data_x0pipe", data_rd_id, 32'h55);
    next_cycle();
    pend_addr = 5'd0;
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h77);
    sample();
    check("t5_ready_x0mdu", mdu_ready, 1'b1);
    check("t5_hit_x0mdu",   pend_hit,  1'b0);
    check("t5_we_x0mdu",    gpr_we_id, 1'b0);
    next_cycle();
    idle();
    sample();
    check("t5_we_after",    gpr_we_id, 1'b0);
    check("t5_hit_after",   pend_hit,  1'b0);
    check("t5_ready_after", mdu_ready, 1'b1);
    next_cycle();

    // Simultaneous push/pop with one entry buffered
    pend_addr = 5'd12;
    drive(1'b1, 5'd3, 32'h400, 1'b1, 5'd11, 32'hB11);
    exp_wr(5'd3, 32'h400);
    next_cycle();
    drive(1'b0, '0, '0, 1'b1, 5'd12, 32'hC12);
    exp_wr(5'd11, 32'hB11);
    sample();
    check("t6_ready_c1", mdu_ready, 1'b1);
    check("t6_hit_c1",   pend_hit,  1'b0);
    next_cycle();
    idle();
    exp_wr(5'd12, 32'hC12);
    sample();
    check("t6_ready_c2", mdu_ready, 1'b1);
    check("t6_hit_c2",   pend_hit,  1'b1);
    check("t6_we_c2",    gpr_we_id, 1'b1);
    next_cycle();
    sample();
    check("t6_we_c3",  gpr_we_id, 1'b0);
    check("t6_hit_c3", pend_hit,  1'b0);
    next_cycle();

    // Reset mid-traffic with two entries buffered
    pend_addr = 5'd13;
    drive(1'b1, 5'd1, 32'h500, 1'b1, 5'd13, 32'h13);
    exp_wr(5'd1, 32'h500);
    next_cycle();
    drive(1'b1, 5'd2, 32'h501, 1'b1, 5'd14, 32'h14);
    exp_wr(5'd2, 32'h501);
    next_cycle();
    drive(1'b1, 5'd3, 32'h502, 1'b0, '0, '0);
    exp_wr(5'd3, 32'h502);
    sample();
    check("t1_ready_full", mdu_ready, 1'b0);
    check("t1_hit_buf",    pend_hit,  1'b1);
    next_cycle();
    idle();
    rst_n = 1'b0;
    sample();
    check("t1_we",    gpr_we_id,  1'b0);
    check("t1_addr",  addr_rd_id, '0);
    check("t1_data",  data_rd_id, '0);
    check("t1_stall", stall_pipe, 1'b0);
    check("t1_hit",   pend_hit,   1'b0);
    check("t1_ready", mdu_ready,  1'b1);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t1_no_stale_we", gpr_we_id, 1'b0);
      check("t1_no_stale_hit", pend_hit, 1'b0);
      next_cycle();
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
